// File: rtl/line_divider.sv
// Iterative unsigned restoring divider producing floor((numer << FRAC_BITS) / denom),
// one quotient bit per clock, for per-line projection in the donut renderer.
module line_divider #(
   parameter int N_WIDTH   = 12,
   parameter int D_WIDTH   = 12,
   parameter int FRAC_BITS = 4,
   localparam int Q_WIDTH  = N_WIDTH + FRAC_BITS
) (
   input  logic               clk48,
   input  logic               rst_n,
   input  logic               start,
   input  logic [N_WIDTH-1:0] numer,
   input  logic [D_WIDTH-1:0] denom,
   output logic               busy,
   output logic               done,
   output logic [Q_WIDTH-1:0] quotient,
   output logic [D_WIDTH-1:0] remainder,
   output logic               div_by_zero
);

   localparam int CNT_W = $clog2(Q_WIDTH + 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [Q_WIDTH-1:0] r_dq;
   logic [D_WIDTH-1:0] r_den;
   logic [D_WIDTH-1:0] r_rem;
   logic               r_busy;
   logic               r_done;
   logic               r_dbz;
   logic [Q_WIDTH-1:0] r_quo;
   logic [D_WIDTH-1:0] r_rem_out;

   logic [D_WIDTH:0]   w_trial;
   logic               w_ge;
   logic [D_WIDTH-1:0] w_diff;
   logic [D_WIDTH-1:0] w_rem_next;
   logic [Q_WIDTH-1:0] w_dq_next;
   logic               w_accept;
   logic               w_last;

   // r_dq holds the dividend: its MSB feeds each trial while quotient bits enter at the LSB.
   // The stored remainder is always below the divisor, so D_WIDTH bits suffice between steps;
   // the trial value itself keeps the extra bit so the compare never truncates.
   assign w_trial    = {r_rem, r_dq[Q_WIDTH-1]};
   assign w_ge       = (w_trial >= {1'b0, r_den});
   assign w_diff     = w_trial[D_WIDTH-1:0] - r_den;
   assign w_rem_next = w_ge ? w_diff : w_trial[D_WIDTH-1:0];
   assign w_dq_next  = {r_dq[Q_WIDTH-2:0], w_ge};
   assign w_accept   = (r_state == S_IDLE) && start;
   assign w_last     = (r_cnt == CNT_W'(1));

   always_ff @(posedge clk48) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_dbz     <= 1'b0;
         r_quo     <= '0;
         r_rem_out <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_RUN;
                  r_cnt   <= CNT_W'(Q_WIDTH);
                  r_rem   <= '0;
                  r_busy  <= 1'b1;
                  r_dbz   <= (denom == '0);
               end
            end
            S_RUN: begin
               r_rem <= w_rem_next;
               r_cnt <= r_cnt - CNT_W'(1);
               if (w_last) begin
                  r_state   <= S_IDLE;
                  r_busy    <= 1'b0;
                  r_done    <= 1'b1;
                  r_quo     <= r_dbz ? '1 : w_dq_next;
                  r_rem_out <= r_dbz ? '0 : w_rem_next;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Operand registers carry no reset; they are always reloaded before use.
   always_ff @(posedge clk48) begin
      if (w_accept) begin
         r_dq  <= {numer, {FRAC_BITS{1'b0}}};
         r_den <= denom;
      end else if (r_state == S_RUN) begin
         r_dq  <= w_dq_next;
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign quotient    = r_quo;
   assign remainder   = r_rem_out;
   assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_line_divider.sv
// Directed and randomized checks of line_divider: table vectors, busy-start rejection,
// back-to-back issue, reset abort, and a reference-model sweep.
module tb_line_divider;

   localparam int N_WIDTH   = 12;
   localparam int D_WIDTH   = 12;
   localparam int FRAC_BITS = 4;
   localparam int Q_WIDTH   = N_WIDTH + FRAC_BITS;

   logic               clk48 = 1'b0;
   logic               rst_n = 1'b0;
   logic               start = 1'b0;
   logic [N_WIDTH-1:0] numer = '0;
   logic [D_WIDTH-1:0] denom = '0;
   logic               busy;
   logic               done;
   logic [Q_WIDTH-1:0] quotient;
   logic [D_WIDTH-1:0] remainder;
   logic               div_by_zero;

   line_divider #(
      .N_WIDTH  (N_WIDTH),
      .D_WIDTH  (D_WIDTH),
      .FRAC_BITS(FRAC_BITS)
   ) dut (
      .clk48      (clk48),
      .rst_n      (rst_n),
      .start      (start),
      .numer      (numer),
      .denom      (denom),
      .busy       (busy),
      .done       (done),
      .quotient   (quotient),
      .remainder  (remainder),
      .div_by_zero(div_by_zero)
   );

   always #5 clk48 = ~clk48;

   int n_checks = 0;
   int n_fail   = 0;
   logic [Q_WIDTH-1:0] prev_q = '0;

   typedef struct {
      logic [N_WIDTH-1:0] n;
      logic [D_WIDTH-1:0] d;
      logic [Q_WIDTH-1:0] q;
      logic [D_WIDTH-1:0] r;
      logic               z;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk48);
      #1;
   endtask

   // Issues one request from idle (or from the done cycle) and stops in the done cycle.
   task automatic run_div(input logic [N_WIDTH-1:0] n, input logic [D_WIDTH-1:0] d,
                          input logic [Q_WIDTH-1:0] eq, input logic [D_WIDTH-1:0] er,
                          input logic ez, input string tag);
      int edges;
      int busy_cnt;
      numer = n;
      denom = d;
      start = 1'b1;
      tick();
      start = 1'b0;
      numer = N_WIDTH'($urandom);
      denom = D_WIDTH'($urandom);
      check({tag, " busy_at_accept"}, 32'(busy), 32'd1);
      check({tag, " q_hold"}, 32'(quotient), 32'(prev_q));
      check({tag, " dbz_at_accept"}, 32'(div_by_zero), 32'(ez));
      edges    = 0;
      busy_cnt = 1;
      while (!done && edges < 40) begin
         tick();
         edges++;
         if (busy) busy_cnt++;
      end
      check({tag, " latency"}, 32'(edges), 32'(Q_WIDTH));
      check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(Q_WIDTH));
      check({tag, " quotient"}, 32'(quotient), 32'(eq));
      check({tag, " remainder"}, 32'(remainder), 32'(er));
      check({tag, " dbz"}, 32'(div_by_zero), 32'(ez));
      prev_q = eq;
   endtask

   task automatic finish_div(input string tag);
      tick();
      check({tag, " done_width"}, 32'(done), 32'd0);
      check({tag, " busy_after"}, 32'(busy), 32'd0);
   endtask

   initial begin
      vecs[0] = '{n: 12'd100,  d: 12'd7,    q: 16'd228,   r: 12'd4,  z: 1'b0};
      vecs[1] = '{n: 12'd4095, d: 12'd1,    q: 16'd65520, r: 12'd0,  z: 1'b0};
      vecs[2] = '{n: 12'd4095, d: 12'd4095, q: 16'd16,    r: 12'd0,  z: 1'b0};
      vecs[3] = '{n: 12'd0,    d: 12'd5,    q: 16'd0,     r: 12'd0,  z: 1'b0};
      vecs[4] = '{n: 12'd50,   d: 12'd0,    q: 16'hFFFF,  r: 12'd0,  z: 1'b1};
      vecs[5] = '{n: 12'd9,    d: 12'd3,    q: 16'd48,    r: 12'd0,  z: 1'b0};
      vecs[6] = '{n: 12'd1,    d: 12'd4095, q: 16'd0,     r: 12'd16, z: 1'b0};
      vecs[7] = '{n: 12'd4095, d: 12'd2,    q: 16'd32760, r: 12'd0,  z: 1'b0};
      vecs[8] = '{n: 12'd7,    d: 12'd3,    q: 16'd37,    r: 12'd1,  z: 1'b0};
      vecs[9] = '{n: 12'd1,    d: 12'd1,    q: 16'd16,    r: 12'd0,  z: 1'b0};

      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst busy", 32'(busy), 32'd0);
      check("rst done", 32'(done), 32'd0);
      check("rst quotient", 32'(quotient), 32'd0);
      check("rst remainder", 32'(remainder), 32'd0);
      check("rst dbz", 32'(div_by_zero), 32'd0);
      rst_n = 1'b1;
      tick();

      // Table vectors
      for (int i = 0; i < 10; i++) begin
         run_div(vecs[i].n, vecs[i].d, vecs[i].q, vecs[i].r, vecs[i].z, $sformatf("vec%0d", i));
         finish_div($sformatf("vec%0d", i));
         tick();
      end

      // Start while busy is ignored, then start in the done cycle is accepted
      begin
         int edges;
         numer = 12'd100;
         denom = 12'd7;
         start = 1'b1;
         tick();
         start = 1'b0;
         edges = 0;
         repeat (4) begin
            tick();
            edges++;
         end
         numer = 12'd9;
         denom = 12'd3;
         start = 1'b1;
         tick();
         edges++;
         start = 1'b0;
         check("ignore busy_held", 32'(busy), 32'd1);
         while (!done && edges < 40) begin
            tick();
            edges++;
         end
         check("ignore latency", 32'(edges), 32'(Q_WIDTH));
         check("ignore quotient", 32'(quotient), 32'd228);
         check("ignore remainder", 32'(remainder), 32'd4);
         prev_q = 16'd228;
         run_div(12'd9, 12'd3, 16'd48, 12'd0, 1'b0, "b2b");
         finish_div("b2b");
      end

      // Reset mid-division aborts without a done pulse
      begin
         int n_done;
         numer = 12'd100;
         denom = 12'd7;
         start = 1'b1;
         tick();
         start = 1'b0;
         repeat (5) tick();
         rst_n = 1'b0;
         tick();
         rst_n = 1'b1;
         check("abort busy", 32'(busy), 32'd0);
         check("abort done", 32'(done), 32'd0);
         check("abort quotient", 32'(quotient), 32'd0);
         check("abort remainder", 32'(remainder), 32'd0);
         check("abort dbz", 32'(div_by_zero), 32'd0);
         n_done = 0;
         repeat (20) begin
            tick();
            if (done) n_done++;
         end
         check("abort no_done", 32'(n_done), 32'd0);
         prev_q = '0;
         run_div(12'd100, 12'd7, 16'd228, 12'd4, 1'b0, "post_abort");
         finish_div("post_abort");
      end

      // Reference-model sweep
      for (int k = 0; k < 1000; k++) begin
         logic [N_WIDTH-1:0] n;
         logic [D_WIDTH-1:0] d;
         logic [Q_WIDTH-1:0] dv;
         logic [Q_WIDTH-1:0] eq;
         logic [Q_WIDTH-1:0] er;
         n  = N_WIDTH'($urandom);
         d  = D_WIDTH'($urandom_range(1, (1 << D_WIDTH) - 1));
         dv = {n, {FRAC_BITS{1'b0}}};
         eq = dv / Q_WIDTH'(d);
         er = dv % Q_WIDTH'(d);
         run_div(n, d, eq, er[D_WIDTH-1:0], 1'b0, $sformatf("rnd%0d", k));
      end
      finish_div("rnd_end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
